// File: rtl/match_tally.sv
// match_tally: rising-edge event counter with threshold alarm and snapshot handshake.
// Define TALLY_SAT_EN for a saturating count; otherwise the count wraps.
module match_tally #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hit,
   input  logic             clr,
   input  logic [WIDTH-1:0] thresh,
   input  logic             snap_req,
   input  logic             snap_ready,
   output logic             snap_valid,
   output logic [WIDTH-1:0] snap_data,
   output logic [WIDTH-1:0] count,
   output logic             alarm,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAXV = '1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } snap_st_t;

   snap_st_t         st, st_nxt;
   logic             hit_d;
   logic             evt;
   logic             load;
   logic [WIDTH-1:0] cnt_nxt;
   logic             ovf_nxt;

   assign evt = hit & ~hit_d;

   always_comb begin
      cnt_nxt = count;
      ovf_nxt = ovf;
      if (clr) begin
         cnt_nxt = '0;
         ovf_nxt = 1'b0;
      end else if (evt) begin
         if (count == MAXV) begin
            ovf_nxt = 1'b1;
`ifdef TALLY_SAT_EN
            cnt_nxt = count;
`else
            cnt_nxt = '0;
`endif
         end else begin
            cnt_nxt = count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_d <= 1'b0;
         count <= '0;
         ovf   <= 1'b0;
         alarm <= 1'b0;
      end else begin
         hit_d <= hit;
         count <= cnt_nxt;
         ovf   <= ovf_nxt;
         alarm <= (cnt_nxt >= thresh);
      end
   end

   // Requests seen while holding are dropped, not queued.
   always_comb begin
      st_nxt = st;
      load   = 1'b0;
      unique case (st)
         IDLE: begin
            if (snap_req) begin
               st_nxt = HOLD;
               load   = 1'b1;
            end
         end
         HOLD: begin
            if (snap_ready) st_nxt = IDLE;
         end
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st        <= IDLE;
         snap_data <= '0;
      end else begin
         st <= st_nxt;
         if (load) snap_data <= count;
      end
   end

   assign snap_valid = (st == HOLD);

endmodule

// File: doc/match_tally.md
MATCH_TALLY -- requirements
Module: match_tally

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter and snapshot data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port hit, input, 1, the match flag from the upstream sequence detector; level-held while a match is present.
REQ-005 The block SHALL have port clr, input, 1, synchronous clear of the count and overflow flag.
REQ-006 The block SHALL have port thresh, input, WIDTH, the alarm threshold.
REQ-007 The block SHALL have port snap_req, input, 1, a request to capture the current count.
REQ-008 The block SHALL have port snap_ready, input, 1, the consumer's acceptance of the snapshot.
REQ-009 The block SHALL have port snap_valid, output, 1, which is high while snap_data holds an unaccepted snapshot.
REQ-010 The block SHALL have port snap_data, output, WIDTH, the captured count.
REQ-011 The block SHALL have port count, output, WIDTH, the live event count (registered).
REQ-012 The block SHALL have port alarm, output, 1, registered flag meaning count >= thresh.
REQ-013 The block SHALL have port ovf, output, 1, sticky counter overflow flag.

Function
REQ-014 The block SHALL register hit into hit_d every cycle and define event = hit AND NOT hit_d, so one count is made per rising edge of hit, however long hit stays high.
REQ-015 On a cycle with event=1 and clr=0, count SHALL increment by 1 at the next edge, following the overflow rule of REQ-023/024.
REQ-016 clr=1 SHALL force count to 0 and ovf to 0 at the next edge; clr SHALL take priority over a simultaneous event, and that event SHALL be dropped; hit_d SHALL still update.
REQ-017 alarm SHALL be registered as (count_next >= thresh), unsigned compare, so it changes in the same cycle as count; thresh=0 gives alarm=1 from the first edge after reset release.
REQ-018 The snapshot FSM SHALL have two states, IDLE (snap_valid=0) and HOLD (snap_valid=1).
REQ-019 In IDLE with snap_req=1, the block SHALL load snap_data with the count register value before that edge's update and move to HOLD; snap_valid SHALL go high the next cycle.
REQ-020 In HOLD, snap_data SHALL stay stable; snap_req SHALL be ignored (not queued); snap_valid=1 with snap_ready=1 SHALL return the FSM to IDLE at that edge.
REQ-021 In HOLD, snap_ready=1 together with snap_req=1 SHALL return the FSM to IDLE only; the request is not captured and one idle cycle is required between snapshots.
REQ-022 clr SHALL NOT affect the snapshot FSM or snap_data.

Configuration
REQ-023 With TALLY_SAT_EN defined, count SHALL saturate at 2^WIDTH-1, and an event arriving at the maximum SHALL set ovf and leave count unchanged.
REQ-024 With TALLY_SAT_EN undefined, count SHALL wrap from 2^WIDTH-1 to 0 on an event, and ovf SHALL be set on that wrap.
REQ-025 Under either setting, ovf SHALL remain set until clr or reset.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for clk, set count=0, ovf=0, alarm=0, hit_d=0, snap_valid=0, snap_data=0, and FSM=IDLE.
REQ-027 Reset asserted mid-snapshot SHALL abandon the snapshot; a hit held high across reset release SHALL count as one event on the first edge after release.

Verification
REQ-028 The bench SHALL cover: hit high for 5 cycles, then low 2 cycles, then high 1 cycle -> count=2, ovf=0.
REQ-029 The bench SHALL cover: thresh=3 with three hit pulses -> alarm rises in the same cycle count becomes 3; thresh then set to 4 -> alarm=0 on the next edge.
REQ-030 The bench SHALL cover: WIDTH=8 with 256 pulses -> TALLY_SAT_EN defined: count=255, ovf=1; undefined: count=0, ovf=1.
REQ-031 The bench SHALL cover: count=7, snap_req pulse with snap_ready=0 for 4 cycles while 2 more pulses arrive -> snap_data=7, snap_valid held for 4 cycles, count=9; snap_ready=1 -> snap_valid=0 next cycle.
REQ-032 The bench SHALL cover: clr and a hit rising edge in the same cycle -> count=0, ovf=0, event lost.
REQ-033 The bench SHALL cover: rst_n pulsed low between clock edges while in HOLD with count=12 -> all outputs 0 at once, FSM=IDLE.
